// File: rtl/wordcount_pkg.sv
// Shared types for the word-count engine: command codes, FSM states and table entry layout.
package wordcount_pkg;

  localparam logic [31:0] CMD_CLEAR = 32'd1;
  localparam logic [31:0] CMD_COUNT = 32'd2;
  localparam logic [31:0] CMD_STORE = 32'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RD_START, S_RD_BEAT, S_RD_WORD, S_WR_START, S_WR_BEAT, S_WR_WAIT
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] key;
    logic [31:0] count;
  } entry_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/wordcount_table.sv
// Associative key/count table: parallel compare, lowest-free insert, one-cycle clear,
// and an 8-entry-wide read port that feeds the write stream.
module wordcount_table
  import wordcount_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int NB = DEPTH / 8,
  localparam int BW = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          upd,
  input  logic [31:0]   key,
  input  logic [BW-1:0] rd_beat,
  output logic [511:0]  rd_data
);

  entry_t [NB-1:0][7:0] tbl;
  logic [DEPTH-1:0]     hit, free, ins;
  logic                 any_hit;

  for (genvar b = 0; b < NB; b++) begin : g_row
    for (genvar j = 0; j < 8; j++) begin : g_col
      assign hit[b*8+j]  = tbl[b][j].valid && (tbl[b][j].key == key);
      assign free[b*8+j] = !tbl[b][j].valid;
    end
  end

  // Entries are never freed individually, so keys stay unique and the
  // lowest free slot is simply the lowest clear valid bit.
  assign ins     = free & (~free + DEPTH'(1));
  assign any_hit = |hit;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      tbl <= '0;
    end else if (upd) begin
      for (int b = 0; b < NB; b++) begin
        for (int j = 0; j < 8; j++) begin
          if (hit[b*8+j])
            tbl[b][j].count <= sat_inc(tbl[b][j].count);
          else if (ins[b*8+j] && !any_hit)
            tbl[b][j] <= '{valid: 1'b1, key: key, count: 32'd1};
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int j = 0; j < 8; j++)
      if (tbl[rd_beat][j].valid)
        rd_data[64*j +: 64] = {tbl[rd_beat][j].count, tbl[rd_beat][j].key};
  end

endmodule

// File: rtl/wordcount_top.sv
// Word-count engine: CLEAR / COUNT (stream words in, tally) / STORE (stream table out)
// between the kernel control registers and the generic read/write masters.
module wordcount_top
  import wordcount_pkg::*;
#(
  parameter int TABLE_DEPTH = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         kick,
  output logic         busy,
  input  logic [31:0]  command,
  input  logic [31:0]  num_of_words,
  input  logic [63:0]  global_memory_offset,
  output logic         reader_ctrl_start,
  input  logic         reader_ctrl_done,
  output logic [63:0]  reader_ctrl_addr_offset,
  output logic [63:0]  reader_ctrl_xfer_size_in_bytes,
  input  logic         reader_s_axis_tvalid,
  output logic         reader_s_axis_tready,
  input  logic [511:0] reader_s_axis_tdata,
  input  logic         reader_s_axis_tlast,
  output logic         writer_ctrl_start,
  input  logic         writer_ctrl_done,
  output logic [63:0]  writer_ctrl_addr_offset,
  output logic [63:0]  writer_ctrl_xfer_size_in_bytes,
  output logic         writer_m_axis_tvalid,
  input  logic         writer_m_axis_tready,
  output logic [511:0] writer_m_axis_tdata
);

  localparam int NB = TABLE_DEPTH / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

  state_t         state;
  logic [63:0]    off_q;
  logic [31:0]    words_left;
  logic [32:0]    wsum;
  logic [511:0]   beat_buf;
  logic [3:0]     word_idx;
  logic           rd_ready, wr_valid, done_seen;
  logic [BW-1:0]  wr_beat;
  logic           unused_inputs;

  assign unused_inputs        = reader_ctrl_done ^ reader_s_axis_tlast;
  assign wsum                 = {1'b0, words_left} + 33'd15;
  assign reader_s_axis_tready = rd_ready;
  assign writer_m_axis_tvalid = wr_valid;

  // The table is static during STORE, so its read port holds tdata through stalls.
  wordcount_table #(.DEPTH(TABLE_DEPTH)) u_table (
    .clk     (clk),
    .reset   (reset),
    .clr     (state == S_CLEAR),
    .upd     (state == S_RD_WORD),
    .key     (beat_buf[{word_idx, 5'd0} +: 32]),
    .rd_beat (wr_beat),
    .rd_data (writer_m_axis_tdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state                          <= S_IDLE;
      busy                           <= 1'b0;
      off_q                          <= '0;
      words_left                     <= '0;
      beat_buf                       <= '0;
      word_idx                       <= '0;
      rd_ready                       <= 1'b0;
      wr_valid                       <= 1'b0;
      done_seen                      <= 1'b0;
      wr_beat                        <= '0;
      reader_ctrl_start              <= 1'b0;
      reader_ctrl_addr_offset        <= '0;
      reader_ctrl_xfer_size_in_bytes <= '0;
      writer_ctrl_start              <= 1'b0;
      writer_ctrl_addr_offset        <= '0;
      writer_ctrl_xfer_size_in_bytes <= '0;
    end else begin
      reader_ctrl_start <= 1'b0;
      writer_ctrl_start <= 1'b0;
      case (state)
        S_IDLE: begin
          // No-op commands and empty COUNTs finish here after one busy cycle.
          if (busy) begin
            busy <= 1'b0;
          end else if (kick) begin
            busy       <= 1'b1;
            off_q      <= global_memory_offset;
            words_left <= num_of_words;
            case (command)
              CMD_CLEAR: state <= S_CLEAR;
              CMD_COUNT: if (num_of_words != 32'd0) state <= S_RD_START;
              CMD_STORE: state <= S_WR_START;
              default:   state <= S_IDLE;
            endcase
          end
        end
        S_CLEAR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_RD_START: begin
          reader_ctrl_start              <= 1'b1;
          reader_ctrl_addr_offset        <= off_q;
          reader_ctrl_xfer_size_in_bytes <= {29'd0, wsum[32:4], 6'd0};
          rd_ready                       <= 1'b1;
          state                          <= S_RD_BEAT;
        end
        S_RD_BEAT: begin
          if (reader_s_axis_tvalid && rd_ready) begin
            beat_buf <= reader_s_axis_tdata;
            rd_ready <= 1'b0;
            word_idx <= '0;
            state    <= S_RD_WORD;
          end
        end
        S_RD_WORD: begin
          words_left <= words_left - 32'd1;
          word_idx   <= word_idx + 4'd1;
          if (words_left == 32'd1) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (word_idx == 4'd15) begin
            rd_ready <= 1'b1;
            state    <= S_RD_BEAT;
          end
        end
        S_WR_START: begin
          writer_ctrl_start              <= 1'b1;
          writer_ctrl_addr_offset        <= off_q;
          writer_ctrl_xfer_size_in_bytes <= 64'(TABLE_DEPTH * 8);
          wr_beat                        <= '0;
          done_seen                      <= 1'b0;
          wr_valid                       <= 1'b1;
          state                          <= S_WR_BEAT;
        end
        S_WR_BEAT: begin
          if (writer_ctrl_done) done_seen <= 1'b1;
          if (wr_valid && writer_m_axis_tready) begin
            if (wr_beat == LAST_BEAT) begin
              wr_valid <= 1'b0;
              state    <= S_WR_WAIT;
            end else begin
              wr_beat <= wr_beat + BW'(1);
            end
          end
        end
        S_WR_WAIT: begin
          if (done_seen || writer_ctrl_done) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wordcount_top.sv
// Directed-sequence bench for wordcount_top with a queue-based reference table.
module tb_wordcount_top;

  localparam int DEPTH  = 64;
  localparam int NBEATS = DEPTH / 8;
  localparam logic [31:0] C_CLEAR = 32'd1;
  localparam logic [31:0] C_COUNT = 32'd2;
  localparam logic [31:0] C_STORE = 32'd3;

  logic         clk = 1'b0;
  logic         reset;
  logic         kick;
  logic         busy;
  logic [31:0]  command;
  logic [31:0]  num_of_words;
  logic [63:0]  global_memory_offset;
  logic         reader_ctrl_start;
  logic         reader_ctrl_done;
  logic [63:0]  reader_ctrl_addr_offset;
  logic [63:0]  reader_ctrl_xfer_size_in_bytes;
  logic         reader_s_axis_tvalid;
  logic         reader_s_axis_tready;
  logic [511:0] reader_s_axis_tdata;
  logic         reader_s_axis_tlast;
  logic         writer_ctrl_start;
  logic         writer_ctrl_done;
  logic [63:0]  writer_ctrl_addr_offset;
  logic [63:0]  writer_ctrl_xfer_size_in_bytes;
  logic         writer_m_axis_tvalid;
  logic         writer_m_axis_tready;
  logic [511:0] writer_m_axis_tdata;

  wordcount_top #(.TABLE_DEPTH(DEPTH)) dut (
    .clk                            (clk),
    .reset                          (reset),
    .kick                           (kick),
    .busy                           (busy),
    .command                        (command),
    .num_of_words                   (num_of_words),
    .global_memory_offset           (global_memory_offset),
    .reader_ctrl_start              (reader_ctrl_start),
    .reader_ctrl_done               (reader_ctrl_done),
    .reader_ctrl_addr_offset        (reader_ctrl_addr_offset),
    .reader_ctrl_xfer_size_in_bytes (reader_ctrl_xfer_size_in_bytes),
    .reader_s_axis_tvalid           (reader_s_axis_tvalid),
    .reader_s_axis_tready           (reader_s_axis_tready),
    .reader_s_axis_tdata            (reader_s_axis_tdata),
    .reader_s_axis_tlast            (reader_s_axis_tlast),
    .writer_ctrl_start              (writer_ctrl_start),
    .writer_ctrl_done               (writer_ctrl_done),
    .writer_ctrl_addr_offset        (writer_ctrl_addr_offset),
    .writer_ctrl_xfer_size_in_bytes (writer_ctrl_xfer_size_in_bytes),
    .writer_m_axis_tvalid           (writer_m_axis_tvalid),
    .writer_m_axis_tready           (writer_m_axis_tready),
    .writer_m_axis_tdata            (writer_m_axis_tdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference table: insertion-ordered keys with their counts.
  logic [31:0] mkey[$];
  logic [31:0] mcnt[$];
  logic [31:0] wbuf[0:511];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_add(input logic [31:0] w);
    for (int i = 0; i < mkey.size(); i++) begin
      if (mkey[i] == w) begin
        if (mcnt[i] != 32'hFFFF_FFFF) mcnt[i] = mcnt[i] + 32'd1;
        return;
      end
    end
    if (mkey.size() < DEPTH) begin
      mkey.push_back(w);
      mcnt.push_back(32'd1);
    end
  endfunction

  function automatic void model_clear();
    mkey.delete();
    mcnt.delete();
  endfunction

  function automatic logic [511:0] exp_beat(input int k);
    logic [511:0] r = '0;
    for (int j = 0; j < 8; j++)
      if (8*k + j < mkey.size()) r[64*j +: 64] = {mcnt[8*k+j], mkey[8*k+j]};
    return r;
  endfunction

  function automatic logic [511:0] beat_of(input int k);
    logic [511:0] r = '0;
    if (k < 32)
      for (int i = 0; i < 16; i++) r[32*i +: 32] = wbuf[16*k + i];
    return r;
  endfunction

  task automatic kick_cmd(input logic [31:0] c, input logic [31:0] n, input logic [63:0] o);
    @(negedge clk);
    command = c; num_of_words = n; global_memory_offset = o; kick = 1'b1;
    @(negedge clk);
    kick = 1'b0;
  endtask

  task automatic do_count(input int nw, input logic [63:0] off, input bit rvalid,
                          input bit kick_mid, input int abort_at);
    int nb = 0, starts = 0, cyc = 0, nbeats;
    nbeats = (nw + 15) / 16;
    if (abort_at < 0)
      for (int i = 0; i < nw; i++) model_add(wbuf[i]);
    kick_cmd(C_COUNT, nw, off);
    chk("count_busy_rise", busy, 1'b1);
    while (busy === 1'b1 && cyc < 5000) begin
      if (reader_ctrl_start === 1'b1) begin
        starts++;
        chk("count_rd_addr", reader_ctrl_addr_offset, off);
        chk("count_rd_size", reader_ctrl_xfer_size_in_bytes, 64'(nbeats) * 64);
      end
      reader_s_axis_tvalid = (nb < nbeats) && (!rvalid || $urandom_range(0, 3) != 0);
      reader_s_axis_tdata  = beat_of(nb);
      if (reader_s_axis_tvalid && reader_s_axis_tready) nb++;
      if (kick_mid && cyc == 5) begin
        command = C_CLEAR; kick = 1'b1;
      end else begin
        kick = 1'b0;
      end
      if (abort_at >= 0 && nb == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    reader_s_axis_tvalid = 1'b0;
    kick = 1'b0;
    if (abort_at >= 0) begin
      model_clear();
    end else begin
      chk("count_done", busy, 1'b0);
      chk("count_beats", nb, nbeats);
      chk("count_rd_starts", starts, (nw > 0) ? 1 : 0);
      if (nw == 0) chk("count_zero_busy_cycles", cyc, 1);
    end
  endtask

  task automatic do_store(input logic [63:0] off, input bit stalls, input bit early);
    int nb = 0, starts = 0, cyc = 0, post = 0;
    bit stalled = 1'b0, done_sent = 1'b0;
    logic [511:0] held = '0;
    kick_cmd(C_STORE, 0, off);
    chk("store_busy_rise", busy, 1'b1);
    while (busy === 1'b1 && cyc < 5000) begin
      if (writer_ctrl_start === 1'b1) begin
        starts++;
        chk("store_wr_addr", writer_ctrl_addr_offset, off);
        chk("store_wr_size", writer_ctrl_xfer_size_in_bytes, 64'(DEPTH * 8));
      end
      if (stalled) chk("store_hold", writer_m_axis_tdata, held);
      writer_ctrl_done = 1'b0;
      if (!done_sent) begin
        if (early && nb == NBEATS - 1) begin
          writer_ctrl_done = 1'b1; done_sent = 1'b1;
        end else if (nb == NBEATS) begin
          post++;
          if (post == 3) begin
            chk("store_wait_done", busy, 1'b1);
            writer_ctrl_done = 1'b1; done_sent = 1'b1;
          end
        end
      end
      writer_m_axis_tready = !stalls || ($urandom_range(0, 2) != 0);
      stalled = writer_m_axis_tvalid && !writer_m_axis_tready;
      held    = writer_m_axis_tdata;
      if (writer_m_axis_tvalid && writer_m_axis_tready) begin
        chk("store_beat", writer_m_axis_tdata, exp_beat(nb));
        nb++;
      end
      @(negedge clk);
      cyc++;
    end
    writer_m_axis_tready = 1'b0;
    writer_ctrl_done = 1'b0;
    chk("store_done", busy, 1'b0);
    chk("store_nbeats", nb, NBEATS);
    chk("store_wr_starts", starts, 1);
  endtask

  initial begin
    logic [31:0] pool[0:79];
    reset = 1'b1; kick = 1'b0; command = '0; num_of_words = '0; global_memory_offset = '0;
    reader_ctrl_done = 1'b0; reader_s_axis_tvalid = 1'b0; reader_s_axis_tdata = '0;
    reader_s_axis_tlast = 1'b0; writer_ctrl_done = 1'b0; writer_m_axis_tready = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rd_start", reader_ctrl_start, 1'b0);
    chk("reset_wr_start", writer_ctrl_start, 1'b0);
    chk("reset_tready", reader_s_axis_tready, 1'b0);
    chk("reset_wr_tvalid", writer_m_axis_tvalid, 1'b0);
    chk("reset_rd_addr", reader_ctrl_addr_offset, 64'd0);

    // CLEAR then dump an empty table.
    kick_cmd(C_CLEAR, 0, 0);
    chk("clear_busy_rise", busy, 1'b1);
    @(negedge clk);
    chk("clear_busy_fall", busy, 1'b0);
    model_clear();
    do_store(64'h8000_0000, 1'b0, 1'b0);

    // Directed 128-word COUNT, full beats, tvalid held high.
    for (int b = 0; b < 32; b++)
      for (int i = 0; i < 16; i++)
        wbuf[16*b+i] = (i < 4) ? 32'h11c0ffee : (i < 8) ? 32'habadcafe :
                       (i < 12) ? 32'hdeadbeef : (i % 2 == 0) ? 32'h89abcdef : 32'h01234567;
    do_count(128, 64'h8000_0000, 1'b0, 1'b0, -1);
    do_store(64'h8000_0000, 1'b0, 1'b0);

    // Partial last beat; trailing words are junk that must not be counted.
    for (int i = 0; i < 512; i++) wbuf[i] = 32'hF000_0000 | 32'(i);
    for (int i = 0; i < 20; i++)
      case ($urandom_range(0, 3))
        0: wbuf[i] = 32'h11c0ffee;
        1: wbuf[i] = 32'h0000_0005;
        2: wbuf[i] = 32'h0000_0006;
        default: wbuf[i] = 32'hdeadbeef;
      endcase
    do_count(20, 64'h1000, 1'b1, 1'b1, -1);
    do_store(64'h2000, 1'b1, 1'b1);

    do_count(0, 64'h40, 1'b0, 1'b0, -1);

    kick_cmd(32'd7, 0, 64'h50);
    chk("nop_busy_rise", busy, 1'b1);
    @(negedge clk);
    chk("nop_busy_fall", busy, 1'b0);
    chk("nop_rd_start", reader_ctrl_start, 1'b0);
    chk("nop_wr_start", writer_ctrl_start, 1'b0);

    // More distinct keys than entries: overflow words are dropped.
    for (int i = 0; i < 80; i++) pool[i] = 32'(i) * 32'h9E37_79B9 + 32'h0123_4567;
    for (int i = 0; i < 512; i++) wbuf[i] = pool[$urandom_range(0, 79)];
    do_count(300, 64'h3000, 1'b1, 1'b0, -1);
    do_store(64'h4000, 1'b1, 1'b0);

    // Reset in the middle of a COUNT leaves an idle engine and an empty table.
    do_count(64, 64'h5000, 1'b0, 1'b0, 2);
    chk("abort_busy", busy, 1'b0);
    chk("abort_tready", reader_s_axis_tready, 1'b0);
    do_store(64'h6000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
